// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder
// Turns PS/2 scan-code set 2 bytes from the receive stage into ASCII characters.
// It tracks the Shift and Caps Lock state and buffers decoded characters in a
// small first-word-fall-through FIFO.
//
// Ports:
//   clk          : system clock, all logic on the rising edge
//   reset        : synchronous, active-high
//   rx_done_tick : one-cycle strobe, rx_data is valid in this cycle
//   rx_data[7:0] : received scan-code byte
//   rd           : pops the FIFO head; ignored when the FIFO is empty
//   char_data    : ASCII character at the FIFO head (0x00 when empty)
//   char_valid   : FIFO is not empty
//   shift_on     : left or right Shift is currently held
//   caps_on      : Caps Lock toggle state
//   overflow     : sticky; a character was dropped because the FIFO was full
module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd,
    output logic [7:0] char_data,
    output logic       char_valid,
    output logic       shift_on,
    output logic       caps_on,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t state_reg, state_next;

    logic          left_held_reg, right_held_reg, caps_reg, overflow_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;

    // Prefix FSM: next state
    always_comb begin
        state_next = state_reg;
        if (rx_done_tick) begin
            case (state_reg)
                IDLE: begin
                    if (rx_data == 8'hE0)      state_next = EXT;
                    else if (rx_data == 8'hF0) state_next = BRK;
                end
                EXT:     state_next = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
                BRK:     state_next = IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // A make code is any non-prefix byte that arrives in IDLE. A break code is the
    // byte that follows a plain F0.
    logic is_make, is_break;
    assign is_make  = rx_done_tick && (state_reg == IDLE) &&
                      (rx_data != 8'hE0) && (rx_data != 8'hF0);
    assign is_break = rx_done_tick && (state_reg == BRK);

    // Character lookup. Letters return their lowercase form and 0 otherwise.
    // Non-letters return an unshifted/shifted pair.
    logic [7:0] letter_code, sym_lower, sym_upper, lookup_char;
    logic       sym_mapped, mapped;

    always_comb begin
        letter_code = 8'h00;
        case (rx_data)
            8'h1C: letter_code = "a";  8'h32: letter_code = "b";
            8'h21: letter_code = "c";  8'h23: letter_code = "d";
            8'h24: letter_code = "e";  8'h2B: letter_code = "f";
            8'h34: letter_code = "g";  8'h33: letter_code = "h";
            8'h43: letter_code = "i";  8'h3B: letter_code = "j";
            8'h42: letter_code = "k";  8'h4B: letter_code = "l";
            8'h3A: letter_code = "m";  8'h31: letter_code = "n";
            8'h44: letter_code = "o";  8'h4D: letter_code = "p";
            8'h15: letter_code = "q";  8'h2D: letter_code = "r";
            8'h1B: letter_code = "s";  8'h2C: letter_code = "t";
            8'h3C: letter_code = "u";  8'h2A: letter_code = "v";
            8'h1D: letter_code = "w";  8'h22: letter_code = "x";
            8'h35: letter_code = "y";  8'h1A: letter_code = "z";
            default: letter_code = 8'h00;
        endcase
    end

    always_comb begin
        sym_mapped = 1'b0;
        sym_lower  = 8'h00;
        sym_upper  = 8'h00;
        case (rx_data)
            8'h45: {sym_mapped, sym_lower, sym_upper} = {1'b1, "0", ")"};
            8'h16: {sym_mapped, sym_lower, sym_upper} = {1'b1, "1", "!"};
            8'h1E: {sym_mapped, sym_lower, sym_upper} = {1'b1, "2", "@"};
            8'h26: {sym_mapped, sym_lower, sym_upper} = {1'b1, "3", "#"};
            8'h25: {sym_mapped, sym_lower, sym_upper} = {1'b1, "4", "$"};
            8'h2E: {sym_mapped, sym_lower, sym_upper} = {1'b1, "5", "%"};
            8'h36: {sym_mapped, sym_lower, sym_upper} = {1'b1, "6", "^"};
            8'h3D: {sym_mapped, sym_lower, sym_upper} = {1'b1, "7", "&"};
            8'h3E: {sym_mapped, sym_lower, sym_upper} = {1'b1, "8", "*"};
            8'h46: {sym_mapped, sym_lower, sym_upper} = {1'b1, "9", "("};
            8'h29: {sym_mapped, sym_lower, sym_upper} = {1'b1, " ", " "};
            8'h5A: {sym_mapped, sym_lower, sym_upper} = {1'b1, 8'h0D, 8'h0D};
            8'h66: {sym_mapped, sym_lower, sym_upper} = {1'b1, 8'h08, 8'h08};
            8'h0D: {sym_mapped, sym_lower, sym_upper} = {1'b1, 8'h09, 8'h09};
            8'h41: {sym_mapped, sym_lower, sym_upper} = {1'b1, ",", "<"};
            8'h49: {sym_mapped, sym_lower, sym_upper} = {1'b1, ".", ">"};
            8'h4E: {sym_mapped, sym_lower, sym_upper} = {1'b1, "-", "_"};
            8'h4A: {sym_mapped, sym_lower, sym_upper} = {1'b1, "/", "?"};
            default: ;
        endcase
    end

    assign mapped = (letter_code != 8'h00) || sym_mapped;

    // Uses the shift/caps state from before this edge. Modifier codes never push,
    // so the order of update and lookup only matters in principle.
    always_comb begin
        if (letter_code != 8'h00)
            lookup_char = (shift_on ^ caps_on) ? (letter_code - 8'd32) : letter_code;
        else
            lookup_char = shift_on ? sym_upper : sym_lower;
    end

    // Modifier state
    always_ff @(posedge clk) begin
        if (reset) begin
            left_held_reg  <= 1'b0;
            right_held_reg <= 1'b0;
            caps_reg       <= 1'b0;
        end else begin
            if (is_make) begin
                if (rx_data == 8'h12) left_held_reg  <= 1'b1;
                if (rx_data == 8'h59) right_held_reg <= 1'b1;
                if (rx_data == 8'h58) caps_reg       <= ~caps_reg;
            end
            if (is_break) begin
                if (rx_data == 8'h12) left_held_reg  <= 1'b0;
                if (rx_data == 8'h59) right_held_reg <= 1'b0;
            end
        end
    end

    // Character FIFO. A full FIFO still accepts a push when a pop happens in the
    // same cycle.
    logic empty, full, pop, push_req, push;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == DEPTH_L);
    assign pop      = rd && !empty;
    assign push_req = is_make && mapped;
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= lookup_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
            if (push_req && full && !pop) overflow_reg <= 1'b1;
        end
    end

    assign char_valid = !empty;
    assign char_data  = empty ? 8'h00 : mem[rd_ptr_reg];
    assign shift_on   = left_held_reg | right_held_reg;
    assign caps_on    = caps_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
module tb_ps2_ascii_decoder;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] char_data;
    logic       char_valid, shift_on, caps_on, overflow;

    ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .rd(rd), .char_data(char_data), .char_valid(char_valid),
        .shift_on(shift_on), .caps_on(caps_on), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model tables, built from keyboard layout strings
    logic [7:0] lo_map [256];
    logic [7:0] hi_map [256];
    bit         is_mapped [256];
    bit         is_letter [256];
    logic [7:0] pool [$];

    // Reference model state
    bit         m_e0, m_f0, m_lh, m_rh, m_caps, m_ovf;
    logic [7:0] m_q [$];

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_lh = 0; m_rh = 0; m_caps = 0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] d, output bit push, output logic [7:0] c);
        bit sh;
        push = 0;
        c = 8'h00;
        sh = m_lh | m_rh;
        if (!m_e0 && !m_f0) begin
            if (d == 8'hE0) m_e0 = 1;
            else if (d == 8'hF0) m_f0 = 1;
            else begin
                if (is_mapped[d]) begin
                    push = 1;
                    if (is_letter[d]) c = (sh ^ m_caps) ? hi_map[d] : lo_map[d];
                    else              c = sh ? hi_map[d] : lo_map[d];
                end
                if (d == 8'h12) m_lh = 1;
                if (d == 8'h59) m_rh = 1;
                if (d == 8'h58) m_caps = !m_caps;
            end
        end else if (m_e0 && !m_f0) begin
            if (d == 8'hF0) m_f0 = 1;
            else m_e0 = 0;
        end else if (m_f0 && !m_e0) begin
            if (d == 8'h12) m_lh = 0;
            if (d == 8'h59) m_rh = 0;
            m_f0 = 0;
        end else begin
            m_e0 = 0;
            m_f0 = 0;
        end
    endtask

    task automatic model_edge(input logic t, input logic [7:0] d, input logic r);
        bit push, do_pop, was_full;
        logic [7:0] c;
        if (reset) begin
            model_reset();
            return;
        end
        push = 0;
        c = 8'h00;
        do_pop = r && (m_q.size() > 0);
        was_full = (m_q.size() == DEPTH);
        if (t) model_byte(d, push, c);
        if (do_pop) void'(m_q.pop_front());
        if (push) begin
            if (!was_full || do_pop) m_q.push_back(c);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check_value("char_valid", 8'(char_valid), 8'(m_q.size() > 0));
        check_value("char_data", char_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
        check_value("shift_on", 8'(shift_on), 8'(m_lh | m_rh));
        check_value("caps_on", 8'(caps_on), 8'(m_caps));
        check_value("overflow", 8'(overflow), 8'(m_ovf));
    endtask

    // One clock: apply inputs, let the model see the same edge, then compare.
    task automatic step(input logic t, input logic [7:0] d, input logic r);
        rx_done_tick = t;
        rx_data = d;
        rd = r;
        @(posedge clk);
        model_edge(t, d, r);
        #1;
        rx_done_tick = 0;
        rd = 0;
        compare_all();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1;
        step(1'b0, 8'h00, 1'b0);
        reset = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++) step(1'b0, 8'h00, 1'b1);
        check_value("drained", 8'(char_valid), 8'h00);
    endtask

    initial begin
        logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
            8'h3D, 8'h3E, 8'h46};
        logic [7:0] sym_codes [8] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h41, 8'h49, 8'h4E, 8'h4A};
        logic [7:0] sym_lo [8] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h2C, 8'h2E, 8'h2D, 8'h2F};
        logic [7:0] sym_hi [8] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h3C, 8'h3E, 8'h5F, 8'h3F};
        logic [7:0] extras [13] = '{8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'hE0, 8'hF0,
            8'hAA, 8'hFA, 8'hE1, 8'hFE, 8'h00, 8'hFF};
        string digit_shifted = ")!@#$%^&*(";

        for (int i = 0; i < 256; i++) begin
            lo_map[i] = 8'h00; hi_map[i] = 8'h00; is_mapped[i] = 0; is_letter[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            lo_map[letter_codes[i]] = 8'(8'h61 + i);
            hi_map[letter_codes[i]] = 8'(8'h41 + i);
            is_mapped[letter_codes[i]] = 1;
            is_letter[letter_codes[i]] = 1;
            pool.push_back(letter_codes[i]);
        end
        for (int i = 0; i < 10; i++) begin
            lo_map[digit_codes[i]] = 8'(8'h30 + i);
            hi_map[digit_codes[i]] = digit_shifted[i];
            is_mapped[digit_codes[i]] = 1;
            pool.push_back(digit_codes[i]);
        end
        for (int i = 0; i < 8; i++) begin
            lo_map[sym_codes[i]] = sym_lo[i];
            hi_map[sym_codes[i]] = sym_hi[i];
            is_mapped[sym_codes[i]] = 1;
            pool.push_back(sym_codes[i]);
        end
        for (int i = 0; i < 13; i++) pool.push_back(extras[i]);

        model_reset();
        do_reset();
        do_reset();

        // Plain make/break: one 'a', valid the cycle after the tick
        check_value("valid_before", 8'(char_valid), 8'h00);
        send(8'h1C);
        check_value("first_char", char_data, 8'h61);
        send(8'hF0); send(8'h1C);
        drain();

        // Shift held: 'A', then released: 'a'
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        check_value("shift_held", 8'(shift_on), 8'h01);
        send(8'hF0); send(8'h12); send(8'h1C);
        drain();

        // Caps on, letters upper, digits ignore caps; shift+caps gives lowercase
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'h12); send(8'h16);
        send(8'h1C);
        check_value("caps_on", 8'(caps_on), 8'h01);
        send(8'hF0); send(8'h12); send(8'h58);
        drain();

        // Extended codes: fake shift, keypad enter, extended break
        send(8'hE0); send(8'h12); send(8'h1C);
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'hF0); send(8'h12);
        drain();

        // Overflow: nine pushes into eight slots, then drain in order
        for (int i = 0; i < DEPTH + 1; i++) send(pool[i]);
        check_value("ovf_set", 8'(overflow), 8'h01);
        drain();

        // Full FIFO with a simultaneous pop and push keeps the new char
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(pool[i + 3]);
        step(1'b1, 8'h29, 1'b1);
        check_value("no_drop_ovf", 8'(overflow), 8'h00);
        drain();

        // Reset in the middle of a break sequence clears the prefix
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check_value("after_reset", char_data, 8'h61);
        drain();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(1'($urandom_range(0, 9) < 6),
                      pool[$urandom_range(0, pool.size() - 1)],
                      1'($urandom_range(0, 9) < 3));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Consumes the byte stream from the PS/2 receive stage (`rx_data` qualified by the one-cycle `rx_done_tick`) and turns scan-code set 2 make/break sequences into ASCII characters. Tracks Shift and Caps Lock state and buffers decoded characters in a small first-word-fall-through FIFO for the application side. Sits directly downstream of the PS/2 receiver, in parallel with the transmit path.

## Interface
- `FIFO_DEPTH`, 8: character FIFO entries; power of two, at least 2.
- `clk` input 1: single system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `rx_done_tick` input 1: one-cycle strobe; `rx_data` valid this cycle.
- `rx_data` input 8: received scan-code byte.
- `rd` input 1: pop head of FIFO; ignored when empty.
- `char_data` output 8: ASCII at FIFO head; valid while `char_valid`.
- `char_valid` output 1: FIFO non-empty.
- `shift_on` output 1: left (0x12) or right (0x59) Shift currently held.
- `caps_on` output 1: Caps Lock toggle state.
- `overflow` output 1: sticky; a character was dropped on a full FIFO.

## Operation
- Prefix FSM advances only on `rx_done_tick`. States: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (after 0xE0,0xF0).
  - IDLE: 0xE0→EXT; 0xF0→BRK; any other byte is a make code, handled, stay IDLE.
  - EXT: 0xF0→EXT_BRK; any other byte→IDLE, discarded (no char, no Shift change; fake-shift E0 12 has no effect).
  - BRK: byte is a release code→IDLE. 0x12/0x59 clear that side's held flag; everything else ignored.
  - EXT_BRK: any byte→IDLE, discarded.
- Make handling (IDLE): 0x12/0x59 set left/right held flag; 0x58 toggles `caps_on` (repeats toggle again); mapped codes push one char; unmapped codes (including 0xAA, 0xFA, 0xE1, 0xFE, 0x00, 0xFF) do nothing. Typematic repeats push each time.
- `shift_on` = left_held OR right_held.
- Letters (1C A,32 B,21 C,23 D,24 E,2B F,34 G,33 H,43 I,3B J,42 K,4B L,3A M,31 N,44 O,4D P,15 Q,2D R,1B S,2C T,3C U,2A V,1D W,22 X,35 Y,1A Z): uppercase iff `shift_on` XOR `caps_on`, else lowercase.
- Digits 45,16,1E,26,25,2E,36,3D,3E,46 = '0'..'9'; with Shift = ')','!','@','#','$','%','^','&','*','('. Caps ignored.
- 29 space, 5A 0x0D, 66 0x08, 0D 0x09 (shift-independent); 41 ','/'<', 49 '.'/'>', 4E '-'/'_', 4A '/'/'?' (unshifted/shifted).
- FIFO: push on mapped make; pop on `rd` && `char_valid`. Full with no pop: char dropped, `overflow` set. Full with simultaneous pop: pop and push both occur, no drop. Empty with push and `rd`: push only.

## Timing
- Reset values: `char_valid`=0, `char_data`=0x00, `shift_on`=0, `caps_on`=0, `overflow`=0, FSM=IDLE, FIFO empty. Reset mid-sequence discards pending prefix and all buffered chars.
- Lookup combinational from `rx_data` and current shift/caps; push registered at the `rx_done_tick` edge. Char from tick at cycle N: `char_valid`=1 and `char_data` valid at N+1 (empty-FIFO case).
- Shift/Caps update at the same edge as the tick; a char in the same byte uses pre-update state (only relevant to modifier codes, which never push).
- Pop at cycle M: next entry (or `char_valid`=0) visible at M+1.
- `overflow` stays 1 until reset.
- Back-to-back ticks on consecutive cycles are accepted.

## Test plan
- Reset then bytes 1C, F0,1C -> one char 0x61 ('a'); `char_valid` rises one cycle after first tick; `shift_on`=0.
- 12, 1C, F0,1C, F0,12, 1C -> chars 'A','a'; `shift_on` 1 between 0x12 and F0,12.
- 58, F0,58, 1C, 12, 16 -> `caps_on`=1, chars 'A','!'; then 12 held + 1C -> 'a'.
- E0,12, 1C -> 'a' (fake shift ignored); E0,5A -> no char; E0,F0,12 -> no state change.
- Push 9 chars with `rd`=0 (depth 8) -> 8 held, `overflow`=1; pop all, order preserved, `char_valid` drops after 8th pop.
- Full FIFO, tick for 29 in same cycle as `rd` -> no drop, `overflow` unchanged, tail = 0x20; reset after F0 then 1C -> 'a' pushed (prefix cleared).
